// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter with TX FIFO on the CPU data bus
// Optional even parity bit per frame when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx,
    output logic        hit
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic       PARITY_EN = 1'b1;
`else
    localparam logic       PARITY_EN = 1'b0;
`endif

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_req, push, wr_en;
    logic [2:0]  state;
    logic [15:0] clk_cnt, div_l, div;
    logic [2:0]  bit_idx;
    logic [7:0]  shifter;
    logic        overrun, busy, bit_end;
`ifdef UART_TX_PARITY_EN
    logic        par;
`endif
    logic        unused_bits;

    assign unused_bits = ^{addr[1:0], data_i[31:16]};

    assign hit      = ce && (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en    = hit && we && (sel != 4'b0000);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = (state == S_IDLE) && !empty;
    assign push_req = wr_en && (addr[3:2] == 2'd0);
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign push     = push_req && (!full || pop);
    assign busy     = (state != S_IDLE);
    assign bit_end  = (clk_cnt == div_l - 16'd1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
            div     <= DEFAULT_DIV;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_req && full && !pop) begin
                overrun <= 1'b1;
            end else if (wr_en && (addr[3:2] == 2'd1) && data_i[3]) begin
                overrun <= 1'b0;
            end
            if (wr_en && (addr[3:2] == 2'd2) && (sel == 4'b1111)) begin
                div <= (data_i[15:0] < 16'd2) ? 16'd2 : data_i[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shifter <= '0;
            div_l   <= DEFAULT_DIV;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (state != S_IDLE) begin
                clk_cnt <= bit_end ? 16'd0 : clk_cnt + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shifter <= mem[rd_ptr[AW-1:0]];
`ifdef UART_TX_PARITY_EN
                        par     <= ^mem[rd_ptr[AW-1:0]];
`endif
                        div_l   <= div;
                        clk_cnt <= 16'd0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shifter <= {1'b0, shifter[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shifter[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx = par;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        data_o = 32'h0;
        if (hit && !we) begin
            case (addr[3:2])
                2'd1:    data_o = {26'b0, PARITY_EN, 1'b0, overrun, busy, full, empty};
                2'd2:    data_o = {16'b0, div};
                default: data_o = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PBIT  = 32'h20;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PBIT  = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst, ce, we, tx, hit;
    logic [31:0] addr, data_i, data_o;
    logic [3:0]  sel;

    uart_tx_mmio dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(data_o), .tx(tx), .hit(hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus a timeline of the frame currently on the wire.
    logic [7:0]  q[$];
    int          m_div;
    logic        m_ovr;
    longint      cyc;
    longint      f_start;
    longint      free_at;
    int          f_div;
    logic        f_valid;
    logic [10:0] f_bits;

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic        exp_hit;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(logic c, logic w, logic [31:0] a, logic [3:0] s,
                                logic [31:0] d, logic eh, logic [31:0] ed);
        vec_t v;
        v.ce = c; v.we = w; v.addr = a; v.sel = s; v.data = d;
        v.exp_hit = eh; v.exp_data = ed;
        return v;
    endfunction

    function automatic logic [10:0] frame(logic [7:0] b);
        logic [10:0] f;
        f = 11'h7FF;
        f[0] = 1'b0;
        f[8:1] = b;
        if (NBITS == 11) f[9] = ^b;
        return f;
    endfunction

    function automatic logic exp_busy();
        return f_valid && ((cyc - f_start) < longint'(NBITS * f_div));
    endfunction

    function automatic logic exp_tx();
        int k;
        if (!exp_busy()) return 1'b1;
        k = int'((cyc - f_start) / longint'(f_div));
        return f_bits[k];
    endfunction

    function automatic logic [31:0] m_status();
        return PBIT | {28'b0, m_ovr, exp_busy(), q.size() == DEPTH, q.size() == 0};
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd1:    return m_status();
            2'd2:    return 32'(m_div);
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        int   lvl;
        logic p;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            m_div = 868; m_ovr = 1'b0; f_valid = 1'b0; free_at = 0;
        end else begin
            lvl = q.size();
            p = (lvl > 0) && (cyc >= free_at);
            if (p) begin
                f_bits  = frame(q.pop_front());
                f_start = cyc;
                f_div   = m_div;
                f_valid = 1'b1;
                free_at = cyc + longint'(NBITS * m_div) + 1;
            end
            if (ce && we && sel != 4'b0 && addr[31:4] == BASE[31:4]) begin
                case (addr[3:2])
                    2'd0: if (lvl == DEPTH && !p) m_ovr = 1'b1; else q.push_back(data_i[7:0]);
                    2'd1: if (data_i[3]) m_ovr = 1'b0;
                    2'd2: if (sel == 4'hF) m_div = (data_i[15:0] < 16'd2) ? 2 : int'(data_i[15:0]);
                    default: ;
                endcase
            end
        end
        #1;
        chk($sformatf("tx@%0d", cyc), tx, exp_tx());
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] s);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d; sel = s;
        tick();
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic rd(string name, logic [31:0] a, logic [31:0] exp);
        ce = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
        #1;
        chk(name, data_o, exp);
        ce = 1'b0;
    endtask

    task automatic drain(int maxc);
        int n;
        n = 0;
        while ((q.size() != 0 || exp_busy()) && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(n < maxc), 32'h1);
        tick();
    endtask

    task automatic count_busy(input int maxc, output int cnt);
        cnt = 0;
        for (int i = 0; i < maxc; i++) begin
            ce = 1'b1; we = 1'b0; addr = BASE + 32'h4;
            #1;
            if (data_o[2]) cnt++;
            ce = 1'b0;
            tick();
        end
    endtask

    initial begin
        int bc, lowc, r;
        logic [31:0] ra;
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
        cyc = 0; m_div = 868; m_ovr = 1'b0; f_valid = 1'b0; free_at = 0;
        f_start = 0; f_div = 2; f_bits = '1;
        tick(); tick();
        rst = 1'b0;

        vt[0]  = mk(1, 0, BASE + 32'h4,  4'hF, 0, 1, 32'h1 | PBIT);
        vt[1]  = mk(1, 0, BASE + 32'h8,  4'hF, 0, 1, 32'd868);
        vt[2]  = mk(1, 0, BASE,          4'hF, 0, 1, 32'h0);
        vt[3]  = mk(1, 0, BASE + 32'hC,  4'hF, 0, 1, 32'h0);
        vt[4]  = mk(0, 0, BASE + 32'h4,  4'hF, 0, 0, 32'h0);
        vt[5]  = mk(1, 1, BASE + 32'h8,  4'h3, 32'd5, 1, 32'h0);
        vt[6]  = mk(1, 0, BASE + 32'h8,  4'hF, 0, 1, 32'd868);
        vt[7]  = mk(1, 1, BASE + 32'h8,  4'hF, 32'hFFFF_0007, 1, 32'h0);
        vt[8]  = mk(1, 0, BASE + 32'h8,  4'hF, 0, 1, 32'd7);
        vt[9]  = mk(1, 1, BASE + 32'h20, 4'hF, 32'hA5, 0, 32'h0);
        vt[10] = mk(1, 0, BASE + 32'h20, 4'hF, 0, 0, 32'h0);
        vt[11] = mk(1, 0, BASE + 32'h4,  4'hF, 0, 1, 32'h1 | PBIT);
        vt[12] = mk(1, 1, BASE + 32'hC,  4'hF, 32'hFFFF_FFFF, 1, 32'h0);
        vt[13] = mk(1, 0, BASE + 32'h7,  4'hF, 0, 1, 32'h1 | PBIT);
        vt[14] = mk(1, 1, BASE,          4'h0, 32'h11, 1, 32'h0);
        vt[15] = mk(1, 0, BASE + 32'h4,  4'hF, 0, 1, 32'h1 | PBIT);
        vt[16] = mk(1, 0, 32'h2000_0004, 4'hF, 0, 0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            ce = vt[i].ce; we = vt[i].we; addr = vt[i].addr; sel = vt[i].sel; data_i = vt[i].data;
            #1;
            chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(vt[i].exp_hit));
            chk($sformatf("vec%0d_data", i), data_o, vt[i].exp_data);
            tick();
            ce = 1'b0; we = 1'b0;
        end

        // Single 0x55 frame at div 4: busy for exactly one frame length.
        wr(BASE + 32'h8, 32'd4, 4'hF);
        wr(BASE, 32'h55, 4'hF);
        count_busy(NBITS * 4 + 20, bc);
        chk("t2_busy_clks", 32'(bc), 32'(NBITS * 4));

        // Clamp: div 1 behaves as 2.
        wr(BASE + 32'h8, 32'd1, 4'hF);
        wr(BASE, 32'h3C, 4'hF);
        count_busy(NBITS * 2 + 10, bc);
        chk("clamp_busy_clks", 32'(bc), 32'(NBITS * 2));

        // Fill the FIFO while a frame runs, then overflow it.
        wr(BASE + 32'h8, 32'd2, 4'hF);
        for (int i = 0; i < 9; i++) wr(BASE, 32'(8'h10 + i), 4'hF);
        rd("t3_full_no_ovr", BASE + 32'h4, 32'h6 | PBIT);
        wr(BASE, 32'hEE, 4'hF);
        rd("t3_overrun", BASE + 32'h4, 32'hE | PBIT);
        wr(BASE + 32'h4, 32'h8, 4'hF);
        rd("t3_ovr_cleared", BASE + 32'h4, 32'h6 | PBIT);
        // Write on a full FIFO in the very cycle it pops: accepted, no overrun.
        for (int i = 0; i < 100 && cyc + 1 < free_at; i++) tick();
        wr(BASE, 32'h99, 4'hF);
        rd("t3_write_on_pop", BASE + 32'h4, 32'h6 | PBIT);
        rd("t3_model_status", BASE + 32'h4, m_status());
        drain(400);
        rd("t3_idle", BASE + 32'h4, 32'h1 | PBIT);

        // Reset in the middle of the data bits discards everything.
        wr(BASE + 32'h8, 32'd4, 4'hF);
        wr(BASE, 32'hF0, 4'hF);
        wr(BASE, 32'h0F, 4'hF);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("t5_tx_after_rst", 32'(tx), 32'h1);
        rst = 1'b0;
        rd("t5_status", BASE + 32'h4, 32'h1 | PBIT);
        rd("t5_div", BASE + 32'h8, 32'd868);
        lowc = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1) lowc++;
        end
        chk("t5_quiet", 32'(lowc), 32'h0);

        // Divider change mid-frame applies from the next frame.
        wr(BASE + 32'h8, 32'd4, 4'hF);
        wr(BASE, 32'hC3, 4'hF);
        wr(BASE, 32'h3C, 4'hF);
        repeat (6) tick();
        wr(BASE + 32'h8, 32'd8, 4'hF);
        rd("t6_div", BASE + 32'h8, 32'd8);
        drain(400);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3) begin
                wr(BASE, $urandom, 4'hF);
            end else if (r == 4) begin
                wr(BASE + 32'h8, 32'($urandom_range(2, 5)), 4'hF);
            end else if (r == 5) begin
                wr(BASE + 32'h4, $urandom, 4'hF);
            end else if (r <= 7) begin
                ra = BASE | {28'b0, 2'($urandom_range(0, 3)), 2'b00};
                rd($sformatf("rand_rd%0d", i), ra, m_read(ra));
                tick();
            end else begin
                tick();
            end
        end
        drain(3000);
        rd("final_status", BASE + 32'h4, m_status());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1);
    end
endmodule
